// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: FSM states, source IDs
// and the one-entry pending slot used by each byte source.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } tx_state_e;

  typedef enum logic {
    SRC_CPU  = 1'b0,
    SRC_ECHO = 1'b1
  } src_e;

  localparam int ARM_TIMEOUT = 2;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } slot_t;

  // Draining frees the slot first, so a same-cycle req is captured.
  function automatic slot_t slot_next(
    slot_t      cur,
    logic       req,
    logic [7:0] din,
    logic       drain
  );
    slot_t nxt;
    nxt = cur;
    if (drain) nxt.vld = 1'b0;
    if (req && !nxt.vld) begin
      nxt.vld  = 1'b1;
      nxt.data = din;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source, transmitter and status signals of the UART TX arbiter.
// master = surrounding peripheral logic, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int AW = 3
);

  logic          cpu_req;
  logic [7:0]    cpu_data;
  logic          echo_en;
  logic          echo_req;
  logic [7:0]    echo_data;
  logic          tx_busy;
  logic          ovf_clr;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ovf_cpu;
  logic          ovf_echo;

  modport master (
    output cpu_req, cpu_data,
    output echo_en, echo_req, echo_data,
    output tx_busy, ovf_clr,
    input  tx_start, tx_data,
    input  fifo_count, fifo_full, fifo_empty,
    input  ovf_cpu, ovf_echo
  );

  modport slave (
    input  cpu_req, cpu_data,
    input  echo_en, echo_req, echo_data,
    input  tx_busy, ovf_clr,
    output tx_start, tx_data,
    output fifo_count, fifo_full, fifo_empty,
    output ovf_cpu, ovf_echo
  );

endinterface

// File: rtl/uart_tx_arbiter_fifo.sv
// Circular byte FIFO between the source arbiter and the TX FSM.
// Head entry is read combinationally; status comes from the count register.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between CPU writes and the RX echo path:
// pending slots -> round-robin arbiter -> FIFO -> start/busy FSM.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [1:0] ARM_LAST = 2'(ARM_TIMEOUT - 1);

  slot_t      cpu_q, cpu_d;
  slot_t      echo_q, echo_d;
  src_e       rr_q, rr_d;
  logic       ovf_cpu_q, ovf_cpu_d;
  logic       ovf_echo_q, ovf_echo_d;
  tx_state_e  state_q, state_d;
  logic [1:0] arm_q, arm_d;
  logic       start_q, start_d;
  logic [7:0] txd_q, txd_d;

  logic        gnt_cpu;
  logic        gnt_echo;
  logic        push;
  logic        pop;
  logic [7:0]  push_data;
  logic [7:0]  head;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        echo_take;
  logic        cpu_drop;
  logic        echo_drop;

  assign echo_take = bus.echo_req & bus.echo_en;

  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_echo = 1'b0;
    rr_d     = rr_q;
    if (!full) begin
      if (cpu_q.vld && echo_q.vld) begin
        if (rr_q == SRC_CPU) begin
          gnt_cpu = 1'b1;
          rr_d    = SRC_ECHO;
        end else begin
          gnt_echo = 1'b1;
          rr_d     = SRC_CPU;
        end
      end else begin
        gnt_cpu  = cpu_q.vld;
        gnt_echo = echo_q.vld;
      end
    end
  end

  assign push      = gnt_cpu | gnt_echo;
  assign push_data = gnt_echo ? echo_q.data : cpu_q.data;

  assign cpu_drop  = bus.cpu_req & cpu_q.vld & ~gnt_cpu;
  assign echo_drop = echo_take & echo_q.vld & ~gnt_echo;

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_comb begin
    cpu_d      = slot_next(cpu_q, bus.cpu_req, bus.cpu_data, gnt_cpu);
    echo_d     = slot_next(echo_q, echo_take, bus.echo_data, gnt_echo);
    ovf_cpu_d  = (ovf_cpu_q & ~bus.ovf_clr) | cpu_drop;
    ovf_echo_d = (ovf_echo_q & ~bus.ovf_clr) | echo_drop;
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    start_d = 1'b0;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop     = 1'b1;
          start_d = 1'b1;
          txd_d   = head;
          arm_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (bus.tx_busy) begin
          state_d = SEND;
        end else if (arm_q == ARM_LAST) begin
          state_d = IDLE;
        end else begin
          arm_d = arm_q + 2'd1;
        end
      end
      SEND: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_q      <= '0;
      echo_q     <= '0;
      rr_q       <= SRC_CPU;
      ovf_cpu_q  <= 1'b0;
      ovf_echo_q <= 1'b0;
      state_q    <= IDLE;
      arm_q      <= '0;
      start_q    <= 1'b0;
      txd_q      <= '0;
    end else begin
      cpu_q      <= cpu_d;
      echo_q     <= echo_d;
      rr_q       <= rr_d;
      ovf_cpu_q  <= ovf_cpu_d;
      ovf_echo_q <= ovf_echo_d;
      state_q    <= state_d;
      arm_q      <= arm_d;
      start_q    <= start_d;
      txd_q      <= txd_d;
    end
  end

  tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.tx_start   = start_q;
  assign bus.tx_data    = txd_q;
  assign bus.fifo_count = count;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.ovf_cpu    = ovf_cpu_q;
  assign bus.ovf_echo   = ovf_echo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based reference model plus a
// start-triggered scoreboard monitor over directed and random traffic.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.AW(AW)) bus ();

  uart_tx_arbiter #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  byte unsigned sb[$];
  byte unsigned txlog[$];

  // reference model state
  bit           m_cv, m_ev;
  byte unsigned m_cd, m_ed;
  int           m_rr;
  byte unsigned q[$];
  bit           m_ovc, m_ove;
  int           m_ph;
  int           m_arm;
  bit           m_start;
  byte unsigned m_data;

  // transmitter emulation: 0 normal, 1 stuck busy, 2 never busy
  int bmode;
  int blen;
  bit pend;
  int bcnt;
  bit en;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cv = 0; m_ev = 0; m_cd = 0; m_ed = 0;
    m_rr = 0; m_ovc = 0; m_ove = 0;
    m_ph = 0; m_arm = 0; m_start = 0; m_data = 0;
    q.delete();
    sb.delete();
    pend = 0;
    bcnt = 0;
  endtask

  task automatic check_outputs();
    chk("tx_start", int'(bus.tx_start), int'(m_start));
    chk("tx_data", int'(bus.tx_data), int'(m_data));
    chk("fifo_count", int'(bus.fifo_count), q.size());
    chk("fifo_full", int'(bus.fifo_full), int'(q.size() == DEPTH));
    chk("fifo_empty", int'(bus.fifo_empty), int'(q.size() == 0));
    chk("ovf_cpu", int'(bus.ovf_cpu), int'(m_ovc));
    chk("ovf_echo", int'(bus.ovf_echo), int'(m_ove));
  endtask

  // Called just after a negedge: check, drive this cycle, advance model.
  task automatic step(input bit cr, input byte unsigned cdv,
                      input bit er, input byte unsigned edv,
                      input bit clr);
    bit b;
    bit pop;
    bit full;
    int g;
    check_outputs();
    case (bmode)
      1: b = 1'b1;
      2: b = 1'b0;
      default: begin
        if (pend) begin
          pend = 0;
          bcnt = blen;
        end
        b = (bcnt > 0);
        if (bcnt > 0) bcnt--;
      end
    endcase
    if (bmode == 0 && bus.tx_start === 1'b1) pend = 1;
    bus.cpu_req   = cr;
    bus.cpu_data  = cdv;
    bus.echo_req  = er;
    bus.echo_data = edv;
    bus.echo_en   = en;
    bus.ovf_clr   = clr;
    bus.tx_busy   = b;

    full = (q.size() == DEPTH);
    pop  = (m_ph == 0) && (q.size() > 0) && !b;
    g    = -1;
    if (!full) begin
      if (m_cv && m_ev) begin
        g    = m_rr;
        m_rr = 1 - g;
      end else if (m_cv) g = 0;
      else if (m_ev) g = 1;
    end
    m_start = pop;
    if (pop) m_data = q.pop_front();
    if (g == 0) begin
      q.push_back(m_cd); sb.push_back(m_cd); m_cv = 0;
    end
    if (g == 1) begin
      q.push_back(m_ed); sb.push_back(m_ed); m_ev = 0;
    end
    if (clr) begin
      m_ovc = 0; m_ove = 0;
    end
    if (cr) begin
      if (m_cv) m_ovc = 1;
      else begin m_cv = 1; m_cd = cdv; end
    end
    if (er && en) begin
      if (m_ev) m_ove = 1;
      else begin m_ev = 1; m_ed = edv; end
    end
    case (m_ph)
      0: if (pop) begin m_ph = 1; m_arm = 0; end
      1: begin
        if (b) m_ph = 2;
        else begin
          m_arm++;
          if (m_arm >= 2) m_ph = 0;
        end
      end
      default: if (!b) m_ph = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    byte unsigned e;
    if (reset === 1'b1 && bus.tx_start === 1'b1) begin
      txlog.push_back(bus.tx_data);
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_tx_data", int'(bus.tx_data), int'(e));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    byte unsigned exp6[6];
    int           d;
    bit           found;
    exp6 = '{8'hA1, 8'hB2, 8'hB2, 8'hA1, 8'hA1, 8'hB2};

    reset = 1'b0;
    bus.cpu_req = 0; bus.cpu_data = 0;
    bus.echo_req = 0; bus.echo_data = 0;
    bus.echo_en = 0; bus.ovf_clr = 0; bus.tx_busy = 0;
    en = 0; bmode = 0; blen = 10;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_empty", int'(bus.fifo_empty), 1);
    chk("rst_start", int'(bus.tx_start), 0);
    check_outputs();
    reset = 1'b1;
    idle(2);

    // single byte, latency 3
    step(1, 8'h55, 0, 0, 0);
    d = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.tx_start === 1'b1) found = 1;
      else begin
        step(0, 0, 0, 0, 0);
        d++;
      end
    end
    chk("latency_found", int'(found), 1);
    chk("latency", d, 3);
    chk("single_data", int'(bus.tx_data), 8'h55);
    idle(16);
    chk("single_empty", int'(bus.fifo_empty), 1);

    // simultaneous requests, round-robin order
    bmode = 1; en = 1;
    for (int r = 0; r < 3; r++) begin
      step(1, 8'hA1, 1, 8'hB2, 0);
      idle(2);
    end
    chk("simul_count", int'(bus.fifo_count), 6);
    txlog.delete();
    bmode = 0; blen = 2;
    idle(80);
    chk("simul_log_size", txlog.size(), 6);
    for (int i = 0; i < 6 && i < txlog.size(); i++)
      chk("simul_order", int'(txlog[i]), int'(exp6[i]));
    en = 0;

    // overflow of the CPU slot
    bmode = 1;
    for (int i = 0; i < 12; i++) step(1, byte'(i), 0, 0, 0);
    chk("ovf_count", int'(bus.fifo_count), 8);
    chk("ovf_full", int'(bus.fifo_full), 1);
    chk("ovf_cpu_set", int'(bus.ovf_cpu), 1);
    chk("ovf_echo_clear", int'(bus.ovf_echo), 0);
    step(1, 8'h99, 0, 0, 1);
    chk("ovf_set_wins", int'(bus.ovf_cpu), 1);
    step(0, 0, 0, 0, 1);
    chk("ovf_cleared", int'(bus.ovf_cpu), 0);
    txlog.delete();
    bmode = 0; blen = 1;
    idle(120);
    chk("ovf_drained", sb.size(), 0);
    chk("ovf_log_size", txlog.size(), 9);
    if (txlog.size() == 9) chk("ovf_slot_byte", int'(txlog[8]), 8);

    // echo disabled
    en = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, byte'(8'hE0 + i), 0);
      idle(1);
    end
    chk("echo_dis_count", int'(bus.fifo_count), 0);
    chk("echo_dis_ovf", int'(bus.ovf_echo), 0);

    // lost start, then normal
    txlog.delete();
    bmode = 2;
    step(1, 8'hC3, 0, 0, 0);
    idle(8);
    chk("lost_one_start", txlog.size(), 1);
    step(1, 8'hC4, 0, 0, 0);
    idle(8);
    bmode = 0; blen = 3;
    step(1, 8'hC5, 0, 0, 0);
    idle(15);
    chk("lost_log_size", txlog.size(), 3);
    if (txlog.size() == 3) chk("lost_next", int'(txlog[2]), 8'hC5);

    // random traffic
    en = 1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) blen = $urandom_range(1, 6);
      step(($urandom_range(0, 2) == 0), byte'($urandom),
           ($urandom_range(0, 2) == 0), byte'($urandom),
           ($urandom_range(0, 29) == 0));
    end
    idle(200);
    chk("rand_drained", sb.size(), 0);

    // reset during SEND with entries queued
    bmode = 0; blen = 10;
    for (int i = 0; i < 6; i++) step(1, byte'(8'h30 + i), 0, 0, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_ph == 2 && q.size() >= 3) found = 1;
      else idle(1);
    end
    chk("reach_send", int'(found), 1);
    bus.cpu_req = 0; bus.echo_req = 0; bus.ovf_clr = 0; bus.tx_busy = 0;
    #2 reset = 1'b0;
    #1;
    chk("rmf_start", int'(bus.tx_start), 0);
    chk("rmf_data", int'(bus.tx_data), 0);
    chk("rmf_count", int'(bus.fifo_count), 0);
    chk("rmf_full", int'(bus.fifo_full), 0);
    chk("rmf_empty", int'(bus.fifo_empty), 1);
    chk("rmf_ovf", int'(bus.ovf_cpu) + int'(bus.ovf_echo), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    txlog.delete();
    idle(20);
    chk("rmf_no_start", txlog.size(), 0);
    step(1, 8'h77, 0, 0, 0);
    idle(20);
    chk("rmf_new_start", txlog.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two byte sources: CPU store writes (peripheral TX data register) and a hardware echo path fed by UART receive events. Each source gets a one-entry pending register. A round-robin arbiter drains the pending registers into a TX FIFO, and an FSM pops the FIFO and sequences the transmitter's start/busy handshake. Status outputs feed the peripheral read mux.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
AW, 3, log2(DEPTH); the count is AW+1 bits wide.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  one-cycle pulse: CPU wrote a TX byte
cpu_data  in  8  CPU byte, valid with cpu_req
echo_en  in  1  echo path enable (config bit)
echo_req  in  1  one-cycle pulse: UART received a byte
echo_data  in  8  received byte, valid with echo_req
tx_busy  in  1  transmitter busy
ovf_clr  in  1  pulse: clear both overflow flags
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to transmit; held stable while the transmitter is busy
fifo_count  out  AW+1  occupied FIFO entries, 0..DEPTH
fifo_full  out  1  fifo_count==DEPTH
fifo_empty  out  1  fifo_count==0
ovf_cpu  out  1  sticky: a CPU byte was dropped
ovf_echo  out  1  sticky: an echo byte was dropped

Behaviour:
- Reset values (asynchronous, active-low): all outputs 0 except fifo_empty=1. FSM goes to IDLE; pointers, pending valids and the RR pointer clear (RR favours CPU first). Reset mid-frame aborts the sequence; tx_start stays 0.
- Capture: a req whose pending slot is empty loads data and sets valid on the next edge. An echo_req with echo_en=0 is ignored with no flag.
- Drop: a req whose slot is still valid, and is not being drained this cycle, drops the new byte. The old byte is kept and ovf_x is set. If the slot drains in the same cycle as the req, the new byte is captured, not dropped.
- Arbiter: at most one FIFO push per cycle, only when !fifo_full. If one slot is valid, push it. If both are valid, grant the source not granted last, then update the RR pointer. A push frees the slot on the same edge.
- FIFO: circular buffer with AW-bit pointers that wrap at DEPTH. A push and a pop in the same cycle leave the count unchanged; a push on a full FIFO is a pop-free no-op (the arbiter stalls). Combinational read of the head entry.
- FSM:
  - IDLE: if !fifo_empty and !tx_busy, pop the head into tx_data, assert tx_start for 1 cycle, go to ARM.
  - ARM: wait for tx_busy=1, then go to SEND. If busy has not risen after 2 cycles, go back to IDLE (start lost, byte discarded).
  - SEND: wait for tx_busy=0, then go to IDLE.
- Latency: an empty system with an idle transmitter gives tx_start 3 cycles after cpu_req (capture, push, pop/start).
- Back-to-back: the next tx_start comes no sooner than 1 cycle after tx_busy falls.
- ovf_clr clears both flags. If a drop occurs in the same cycle as ovf_clr, set wins.
- fifo_count, fifo_full and fifo_empty are registered or derived from registered state; no combinational path from req inputs.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, ARM, SEND); source IDs SRC_CPU=0, SRC_ECHO=1; ARM_TIMEOUT=2.
- One sub-module: tx_fifo (DEPTH/AW params; push, pop, din, dout, count, full, empty). Arbiter, pending slots and FSM stay in the top.

Test Plan:
- Single byte: cpu_req with 8'h55, transmitter model raises busy 1 cycle after start for 10 cycles -> tx_start exactly 3 cycles after req with tx_data=8'h55; FSM back in IDLE after busy falls; fifo_empty=1.
- Simultaneous reqs: cpu 8'hA1 and echo 8'hB2 (echo_en=1) in the same cycle, repeated 3 times with tx_busy held 1 -> FIFO order A1,B2,B2,A1,A1,B2 (RR alternates); fifo_count=6.
- Overflow: tx_busy held 1, 12 cpu_req pulses with data 0..11 -> fifo_count=8 and the pending slot holds 8; later reqs are dropped, so ovf_cpu=1 and ovf_echo=0. ovf_clr then clears the flag.
- Echo disabled: echo_en=0 with 4 echo_req pulses -> no push, no ovf_echo; fifo_count stays 0.
- Lost start: transmitter never raises busy -> tx_start once, FSM returns to IDLE after 2 ARM cycles, next byte starts normally.
- Reset mid-frame: assert reset during SEND with 3 entries queued -> all outputs at reset values immediately; after release no tx_start until a new req.
